pcie_rx_cmd_split: RTL and testbench



---
 rtl/pcie_rx_cmd_split_pkg.sv | 17 +
 rtl/pcie_rx_cmd_split_if.sv | 31 +++
 rtl/pcie_rx_cmd_split.sv | 87 ++++++++
 tb/tb_pcie_rx_cmd_split.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rx_cmd_split_pkg.sv
// Shared constants and types for the PCIe RX DMA command splitter.
package pcie_rx_cmd_split_pkg;

  // Command entry layout: {addr[47:6], chunk_len_units-1}
  localparam int ADDR_LSB = 4;
  localparam int LEN_MSB  = 3;

  // A chunk never exceeds 1 KB, i.e. 16 units of 64 bytes
  localparam int MAX_CHUNK_UNITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } split_state_e;

endpackage

// File: rtl/pcie_rx_cmd_split_if.sv
// Request handshake plus RX DMA command FIFO write port.
// The requester/FIFO side is the master, the splitter is the slave.
interface pcie_rx_cmd_split_if #(
  parameter int C_PCIE_ADDR_WIDTH = 48,
  parameter int C_REQ_LEN_WIDTH   = 16
);
  localparam int AW = C_PCIE_ADDR_WIDTH - 6;

  logic                       req_valid;
  logic [AW-1:0]              req_addr;
  logic [C_REQ_LEN_WIDTH-1:0] req_len;
  logic                       req_ready;

  logic                       pcie_rx_cmd_wr_en;
  logic [AW+3:0]              pcie_rx_cmd_wr_data;
  logic                       pcie_rx_cmd_full_n;

  modport master (
    output req_valid, req_addr, req_len,
    input  req_ready,
    input  pcie_rx_cmd_wr_en, pcie_rx_cmd_wr_data,
    output pcie_rx_cmd_full_n
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    output req_ready,
    output pcie_rx_cmd_wr_en, pcie_rx_cmd_wr_data,
    input  pcie_rx_cmd_full_n
  );
endinterface

// File: rtl/pcie_rx_cmd_split.sv
// Splits one host-read request into chunks of at most 1 KB that never
// cross a 1 KB boundary, writing one command entry per chunk.
module pcie_rx_cmd_split
  import pcie_rx_cmd_split_pkg::*;
#(
  parameter int C_PCIE_ADDR_WIDTH = 48,
  parameter int C_REQ_LEN_WIDTH   = 16
) (
  input  logic               pcie_user_clk,
  input  logic               pcie_user_rst_n,
  pcie_rx_cmd_split_if.slave bus,
  output logic               split_done,
  output logic               split_busy
);
  localparam int AW = C_PCIE_ADDR_WIDTH - 6;
  localparam int LW = C_REQ_LEN_WIDTH;

  split_state_e   state_q, state_d;
  logic [AW-1:0]  cur_addr_q, cur_addr_d;
  logic [LW-1:0]  remain_q, remain_d;

  logic [4:0]     room;
  logic [4:0]     chunk;
  logic [4:0]     chunk_m1;

  // Chunk size: distance to the next 1 KB boundary, clipped to what is left
  always_comb begin
    room     = 5'(MAX_CHUNK_UNITS) - {1'b0, cur_addr_q[3:0]};
    chunk    = (remain_q < LW'(room)) ? remain_q[4:0] : room;
    chunk_m1 = chunk - 5'd1;
  end

  // Next-state, register updates and outputs
  always_comb begin
    state_d                 = state_q;
    cur_addr_d              = cur_addr_q;
    remain_d                = remain_q;
    bus.req_ready           = (state_q == ST_IDLE);
    bus.pcie_rx_cmd_wr_en   = 1'b0;
    bus.pcie_rx_cmd_wr_data = '0;
    split_done              = (state_q == ST_DONE);
    split_busy              = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cur_addr_d = bus.req_addr;
          remain_d   = bus.req_len;
          state_d    = (bus.req_len != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        // Entry is presented even while stalled so it stays stable
        bus.pcie_rx_cmd_wr_data[ADDR_LSB +: AW] = cur_addr_q;
        bus.pcie_rx_cmd_wr_data[LEN_MSB:0]      = chunk_m1[3:0];
        bus.pcie_rx_cmd_wr_en                   = bus.pcie_rx_cmd_full_n;
        if (bus.pcie_rx_cmd_full_n) begin
          cur_addr_d = cur_addr_q + AW'(chunk);
          remain_d   = remain_q - LW'(chunk);
          if (remain_q == LW'(chunk)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and working registers
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
    end
  end

endmodule

// File: tb/tb_pcie_rx_cmd_split.sv
// Directed bench for pcie_rx_cmd_split with a queue-based scoreboard:
// stimulus pushes expected command entries / done pulses with their
// expected cycle, a negedge monitor pops and compares.
module tb_pcie_rx_cmd_split;

  logic clk = 1'b0;
  logic rst_n;
  logic split_done;
  logic split_busy;
  int   cyc = 0;

  pcie_rx_cmd_split_if #(.C_PCIE_ADDR_WIDTH(48), .C_REQ_LEN_WIDTH(16)) bus ();

  pcie_rx_cmd_split #(.C_PCIE_ADDR_WIDTH(48), .C_REQ_LEN_WIDTH(16)) dut (
    .pcie_user_clk   (clk),
    .pcie_user_rst_n (rst_n),
    .bus             (bus),
    .split_done      (split_done),
    .split_busy      (split_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [45:0] data;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm, input string what);
    n_total++;
    $display("FAIL %s: got %s expected nothing (cycle %0d)", nm, what, cyc);
  endtask

  function automatic logic [45:0] ent(input logic [41:0] a, input logic [3:0] l);
    return {a, l};
  endfunction

  task automatic push_wr(input logic [41:0] a, input logic [3:0] l, input int at);
    exp_t e;
    e.data = ent(a, l);
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: compare every write and every done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pcie_rx_cmd_wr_en) begin
        $display("wr   cycle %0d data 0x%012h", cyc, bus.pcie_rx_cmd_wr_data);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_wr", $sformatf("0x%0h", bus.pcie_rx_cmd_wr_data));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_data", 64'(bus.pcie_rx_cmd_wr_data), 64'(e.data));
          chk("wr_cycle", 64'(cyc), 64'(e.at));
        end
      end
      if (split_done) begin
        $display("done cycle %0d", cyc);
        if (done_q.size() == 0) fail_now("unexpected_done", "split_done");
        else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) fail_now("idle_timeout", "busy");
  endtask

  // Drive one request for a single cycle; acc = the cycle it is accepted in.
  // Returns 1 time unit into cycle acc+1.
  task automatic issue(input logic [41:0] a, input logic [15:0] l);
    wait_idle();
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    acc = cyc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic settle();
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                  = 1'b0;
    bus.req_valid          = 1'b0;
    bus.req_addr           = '0;
    bus.req_len            = '0;
    bus.pcie_rx_cmd_full_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_wr_en", 64'(bus.pcie_rx_cmd_wr_en), 64'd0);
    chk("rst_wr_data", 64'(bus.pcie_rx_cmd_wr_data), 64'd0);
    chk("rst_done", 64'(split_done), 64'd0);
    chk("rst_busy", 64'(split_busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned 1 KB request: one write, done one cycle later
    issue(42'h40, 16'd16);
    push_wr(42'h40, 4'hF, acc + 1);
    done_q.push_back(acc + 2);
    chk("t1_ready_drop", 64'(bus.req_ready), 64'd0);
    chk("t1_busy", 64'(split_busy), 64'd1);
    settle();

    // 0x1380 + 5 units crosses 0x1400: 2 units then 3 units
    issue(42'h4E, 16'd5);
    push_wr(42'h4E, 4'h1, acc + 1);
    push_wr(42'h50, 4'h2, acc + 2);
    done_q.push_back(acc + 3);
    settle();

    // 4 KB from 0: four back-to-back 1 KB chunks; a request offered
    // while busy must be ignored
    issue(42'h0, 16'd64);
    push_wr(42'h00, 4'hF, acc + 1);
    push_wr(42'h10, 4'hF, acc + 2);
    push_wr(42'h20, 4'hF, acc + 3);
    push_wr(42'h30, 4'hF, acc + 4);
    done_q.push_back(acc + 5);
    bus.req_valid = 1'b1;
    bus.req_addr  = 42'h123;
    bus.req_len   = 16'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    settle();

    // Same request with a 3-cycle FIFO stall after the 2nd write
    issue(42'h0, 16'd64);
    push_wr(42'h00, 4'hF, acc + 1);
    push_wr(42'h10, 4'hF, acc + 2);
    push_wr(42'h20, 4'hF, acc + 6);
    push_wr(42'h30, 4'hF, acc + 7);
    done_q.push_back(acc + 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.pcie_rx_cmd_full_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wr_en", 64'(bus.pcie_rx_cmd_wr_en), 64'd0);
      chk("stall_wr_data", 64'(bus.pcie_rx_cmd_wr_data), 64'(ent(42'h20, 4'hF)));
      @(posedge clk); #1;
    end
    bus.pcie_rx_cmd_full_n = 1'b1;
    settle();

    // Zero length: no writes, done at accept+1, ready back at accept+2
    issue(42'h77, 16'd0);
    done_q.push_back(acc + 1);
    chk("zl_ready_low", 64'(bus.req_ready), 64'd0);
    chk("zl_busy", 64'(split_busy), 64'd1);
    @(posedge clk); #1;
    chk("zl_ready_back", 64'(bus.req_ready), 64'd1);
    chk("zl_busy_clear", 64'(split_busy), 64'd0);
    settle();

    // Reset after the first of four writes: request abandoned
    issue(42'h0, 16'd64);
    push_wr(42'h00, 4'hF, acc + 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", 64'(bus.pcie_rx_cmd_wr_en), 64'd0);
    chk("rst_mid_busy", 64'(split_busy), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;

    chk("wr_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
